// File: rtl/fb_arbiter_if.sv
// fb_arbiter_if: requester-side bus of the frame-buffer arbiter.
//
// Handshake: a requester raises req with address (and write data) and must
// hold all of them stable until the cycle where req && gnt is true; that
// cycle is the accept. gnt is combinational from the arbiter and at most one
// of disp_gnt / eng_gnt is high in any cycle. rvalid pulses for exactly one
// cycle two cycles after an accepted read, with rdata valid in that cycle.
// Swap signals are only meaningful when FB_DOUBLE_BUFFER_EN is defined.
interface fb_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;

  logic              eng_req;
  logic              eng_we;
  logic [ADDR_W-1:0] eng_addr;
  logic [DATA_W-1:0] eng_wdata;
  logic              eng_gnt;
  logic              eng_rvalid;
  logic [DATA_W-1:0] eng_rdata;

  logic              eng_swap;
  logic              swap_pending;
  logic              swap_done;

  modport master (
    output disp_req, disp_addr, eng_req, eng_we, eng_addr, eng_wdata, eng_swap,
    input  disp_gnt, disp_rvalid, disp_rdata, eng_gnt, eng_rvalid, eng_rdata,
    input  swap_pending, swap_done
  );

  modport slave (
    input  disp_req, disp_addr, eng_req, eng_we, eng_addr, eng_wdata, eng_swap,
    output disp_gnt, disp_rvalid, disp_rdata, eng_gnt, eng_rvalid, eng_rdata,
    output swap_pending, swap_done
  );
endinterface

// File: rtl/fb_arbiter.sv
// fb_arbiter: shares one single-port synchronous frame-buffer RAM between the
// display line fetcher (priority) and the graphics engine (bounded wait of
// DISP_BURST cycles). RAM command is registered one cycle after accept, read
// data returns one cycle later tagged back to its owner.
// Optional feature macro: FB_DOUBLE_BUFFER_EN (front/back buffer with swap at
// the end_frame rising edge). Without it the buffer bit is always 0.
// last_dbg exposes the arbitration state (0 IDLE, 1 DISP, 2 ENG).
module fb_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int DISP_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              end_frame,
  fb_arbiter_if.slave       bus,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        last_dbg
);

  typedef enum logic [1:0] {
    LAST_IDLE = 2'd0,
    LAST_DISP = 2'd1,
    LAST_ENG  = 2'd2
  } last_e;

  localparam logic [7:0] BURST = 8'(DISP_BURST);

  last_e             last_q, last_d;
  logic [7:0]        run_q, run_d;
  logic              disp_gnt_c, eng_gnt_c;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              disp_tag_q, disp_tag_d;
  logic              eng_tag_q, eng_tag_d;
  logic              disp_rvalid_q, disp_rvalid_d;
  logic              eng_rvalid_q, eng_rvalid_d;
  logic              end_frame_q, end_frame_d;
  logic              frame_edge;
  logic              front_q, front_d;
  logic              swap_pending_q, swap_pending_d;
  logic              swap_done_q, swap_done_d;
  logic              disp_buf, eng_buf;

  assign frame_edge = end_frame & ~end_frame_q;
  assign disp_buf   = front_q;

  // Grant decision: starvation limit first, then display priority, then engine.
  // Reset suppresses grants in the same cycle so nothing is accepted.
  always_comb begin
    disp_gnt_c = 1'b0;
    eng_gnt_c  = 1'b0;
    if (!rst) begin
      if (bus.eng_req && (run_q == BURST)) begin
        eng_gnt_c = 1'b1;
      end else if (bus.disp_req) begin
        disp_gnt_c = 1'b1;
      end else if (bus.eng_req) begin
        eng_gnt_c = 1'b1;
      end
    end
  end

  // Next-state of arbitration bookkeeping, RAM command and read-return tags.
  always_comb begin
    run_d = run_q;
    if (eng_gnt_c || !bus.disp_req) begin
      run_d = 8'd0;
    end else if (disp_gnt_c && bus.eng_req) begin
      run_d = run_q + 8'd1;
    end

    last_d = LAST_IDLE;
    if (disp_gnt_c) begin
      last_d = LAST_DISP;
    end else if (eng_gnt_c) begin
      last_d = LAST_ENG;
    end

    mem_en_d    = disp_gnt_c | eng_gnt_c;
    mem_we_d    = eng_gnt_c & bus.eng_we;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (disp_gnt_c) begin
      mem_addr_d = {disp_buf, bus.disp_addr};
    end else if (eng_gnt_c) begin
      mem_addr_d = {eng_buf, bus.eng_addr};
      if (bus.eng_we) begin
        mem_wdata_d = bus.eng_wdata;
      end
    end

    // Tag travels with the command; the registered tag becomes rvalid when
    // the RAM data appears one cycle after mem_en.
    disp_tag_d    = disp_gnt_c;
    eng_tag_d     = eng_gnt_c & ~bus.eng_we;
    disp_rvalid_d = disp_tag_q;
    eng_rvalid_d  = eng_tag_q;
    end_frame_d   = end_frame;
  end

`ifdef FB_DOUBLE_BUFFER_EN
  assign eng_buf = ~front_q;

  // Swap request latches until the frame-boundary edge; a request in the edge
  // cycle itself is honoured at that edge.
  always_comb begin
    front_d        = front_q;
    swap_pending_d = swap_pending_q;
    swap_done_d    = 1'b0;
    if (frame_edge && (swap_pending_q || bus.eng_swap)) begin
      front_d        = ~front_q;
      swap_pending_d = 1'b0;
      swap_done_d    = 1'b1;
    end else if (bus.eng_swap) begin
      swap_pending_d = 1'b1;
    end
  end
`else
  logic unused_swap;
  assign eng_buf     = 1'b0;
  assign unused_swap = ^{bus.eng_swap, frame_edge};

  // Single-buffer build: buffer bit and swap status stay at zero.
  always_comb begin
    front_d        = 1'b0;
    swap_pending_d = 1'b0;
    swap_done_d    = 1'b0;
  end
`endif

  // All state registers, cleared together by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q         <= LAST_IDLE;
      run_q          <= 8'd0;
      mem_en_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      disp_tag_q     <= 1'b0;
      eng_tag_q      <= 1'b0;
      disp_rvalid_q  <= 1'b0;
      eng_rvalid_q   <= 1'b0;
      end_frame_q    <= 1'b0;
      front_q        <= 1'b0;
      swap_pending_q <= 1'b0;
      swap_done_q    <= 1'b0;
    end else begin
      last_q         <= last_d;
      run_q          <= run_d;
      mem_en_q       <= mem_en_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      disp_tag_q     <= disp_tag_d;
      eng_tag_q      <= eng_tag_d;
      disp_rvalid_q  <= disp_rvalid_d;
      eng_rvalid_q   <= eng_rvalid_d;
      end_frame_q    <= end_frame_d;
      front_q        <= front_d;
      swap_pending_q <= swap_pending_d;
      swap_done_q    <= swap_done_d;
    end
  end

  assign bus.disp_gnt     = disp_gnt_c;
  assign bus.eng_gnt      = eng_gnt_c;
  assign bus.disp_rvalid  = disp_rvalid_q;
  assign bus.eng_rvalid   = eng_rvalid_q;
  // Read data passes straight through from the RAM while its owner is valid.
  assign bus.disp_rdata   = disp_rvalid_q ? mem_rdata : '0;
  assign bus.eng_rdata    = eng_rvalid_q ? mem_rdata : '0;
  assign bus.swap_pending = swap_pending_q;
  assign bus.swap_done    = swap_done_q;
  assign mem_en           = mem_en_q;
  assign mem_we           = mem_we_q;
  assign mem_addr         = mem_addr_q;
  assign mem_wdata        = mem_wdata_q;
  assign last_dbg         = last_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed bench for fb_arbiter with a behavioural RAM.
// Table rows cover single-cycle grant/command/return behaviour; hand-written
// sequences cover the burst limit, reset with a read in flight and swapping.
module tb_fb_arbiter;

  localparam int AW = 17;
  localparam int DW = 8;
`ifdef FB_DOUBLE_BUFFER_EN
  localparam logic EB = 1'b1;
`else
  localparam logic EB = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic end_frame;
  always #20 clk = ~clk;

  fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic          mem_en, mem_we;
  logic [AW:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    last_dbg;

  fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DISP_BURST(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .end_frame (end_frame),
    .bus       (bus),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .last_dbg  (last_dbg)
  );

  // Behavioural RAM: unwritten words read as low address byte + 0x3C.
  function automatic logic [7:0] init_val(input logic [AW:0] a);
    return a[7:0] + 8'h3C;
  endfunction

  logic [7:0] wr_mem [logic [AW:0]];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) wr_mem[mem_addr] = mem_wdata;
      else mem_rdata <= wr_mem.exists(mem_addr) ? wr_mem[mem_addr] : init_val(mem_addr);
    end
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] disp_exp_q[$];
  logic [DW-1:0] eng_exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_all_zero(input string p);
    chk({p, "_disp_gnt"},     32'(bus.disp_gnt), 0);
    chk({p, "_eng_gnt"},      32'(bus.eng_gnt), 0);
    chk({p, "_disp_rvalid"},  32'(bus.disp_rvalid), 0);
    chk({p, "_eng_rvalid"},   32'(bus.eng_rvalid), 0);
    chk({p, "_disp_rdata"},   32'(bus.disp_rdata), 0);
    chk({p, "_eng_rdata"},    32'(bus.eng_rdata), 0);
    chk({p, "_swap_pending"}, 32'(bus.swap_pending), 0);
    chk({p, "_swap_done"},    32'(bus.swap_done), 0);
    chk({p, "_mem_en"},       32'(mem_en), 0);
    chk({p, "_mem_we"},       32'(mem_we), 0);
    chk({p, "_mem_addr"},     32'(mem_addr), 0);
    chk({p, "_mem_wdata"},    32'(mem_wdata), 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.disp_req  = 1'b0;
    bus.disp_addr = '0;
    bus.eng_req   = 1'b0;
    bus.eng_we    = 1'b0;
    bus.eng_addr  = '0;
    bus.eng_wdata = '0;
    bus.eng_swap  = 1'b0;
  endtask

  // Single read from one requester, then check the buffer bit of the command.
  task automatic issue_rd(input logic is_eng, input logic [AW-1:0] a,
                          input logic exp_msb, input string nm);
    if (is_eng) begin
      bus.eng_req = 1'b1; bus.eng_we = 1'b0; bus.eng_addr = a;
    end else begin
      bus.disp_req = 1'b1; bus.disp_addr = a;
    end
    @(negedge clk);
    chk({nm, "_gnt"}, 32'(is_eng ? bus.eng_gnt : bus.disp_gnt), 1);
    tick();
    bus.eng_req  = 1'b0;
    bus.disp_req = 1'b0;
    @(negedge clk);
    chk({nm, "_maddr"}, 32'(mem_addr), 32'({exp_msb, a}));
    tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic          e_req;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          x_dgnt;
    logic          x_egnt;
    logic          x_men;
    logic          x_mwe;
    logic [AW:0]   x_maddr;
    logic [DW-1:0] x_mwdata;
    logic          x_drv;
    logic          x_erv;
    logic [DW-1:0] x_rdata;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  int dcnt, ecnt, wait_c, max_wait, done_cnt, rv_cnt;

  initial begin
    // Expected mem outputs in a row are the command registered from the
    // previous row's accept; rvalid/rdata are from two rows back.
    vecs[0]  = '{1'b1, 17'h00010, 1'b0, 1'b0, 17'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 18'h0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 17'h0, 1'b0, 1'b0, 17'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, {1'b0, 17'h00010}, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 17'h0, 1'b0, 1'b0, 17'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 18'h0, 8'h00, 1'b1, 1'b0, 8'h4C};
    vecs[3]  = '{1'b0, 17'h0, 1'b1, 1'b1, 17'h01234, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 18'h0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 17'h0, 1'b1, 1'b0, 17'h01234, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, {EB, 17'h01234}, 8'h5A, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 17'h0, 1'b0, 1'b0, 17'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, {EB, 17'h01234}, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[6]  = '{1'b0, 17'h0, 1'b0, 1'b0, 17'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 18'h0, 8'h00, 1'b0, 1'b1, 8'h5A};
    vecs[7]  = '{1'b1, 17'h00020, 1'b1, 1'b0, 17'h00040, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 18'h0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[8]  = '{1'b0, 17'h0, 1'b1, 1'b0, 17'h00040, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, {1'b0, 17'h00020}, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 17'h0, 1'b0, 1'b0, 17'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, {EB, 17'h00040}, 8'h00, 1'b1, 1'b0, 8'h5C};
    vecs[10] = '{1'b0, 17'h0, 1'b0, 1'b0, 17'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 18'h0, 8'h00, 1'b0, 1'b1, 8'h7C};
    vecs[11] = '{1'b0, 17'h0, 1'b0, 1'b0, 17'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 18'h0, 8'h00, 1'b0, 1'b0, 8'h00};

    // ---- reset with both requesters idle ----
    rst = 1'b1;
    end_frame = 1'b0;
    drive_idle();
    repeat (3) tick();
    @(negedge clk);
    check_all_zero("reset");
    tick();
    rst = 1'b0;

    // ---- table ----
    for (int i = 0; i < NV; i++) begin
      bus.disp_req  = vecs[i].d_req;
      bus.disp_addr = vecs[i].d_addr;
      bus.eng_req   = vecs[i].e_req;
      bus.eng_we    = vecs[i].e_we;
      bus.eng_addr  = vecs[i].e_addr;
      bus.eng_wdata = vecs[i].e_wdata;
      @(negedge clk);
      chk($sformatf("row%0d_disp_gnt", i), 32'(bus.disp_gnt), 32'(vecs[i].x_dgnt));
      chk($sformatf("row%0d_eng_gnt", i), 32'(bus.eng_gnt), 32'(vecs[i].x_egnt));
      chk($sformatf("row%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].x_men));
      if (vecs[i].x_men) begin
        chk($sformatf("row%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].x_mwe));
        chk($sformatf("row%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].x_maddr));
      end
      if (vecs[i].x_mwe)
        chk($sformatf("row%0d_mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].x_mwdata));
      chk($sformatf("row%0d_disp_rvalid", i), 32'(bus.disp_rvalid), 32'(vecs[i].x_drv));
      chk($sformatf("row%0d_eng_rvalid", i), 32'(bus.eng_rvalid), 32'(vecs[i].x_erv));
      if (vecs[i].x_drv)
        chk($sformatf("row%0d_disp_rdata", i), 32'(bus.disp_rdata), 32'(vecs[i].x_rdata));
      if (vecs[i].x_erv)
        chk($sformatf("row%0d_eng_rdata", i), 32'(bus.eng_rdata), 32'(vecs[i].x_rdata));
      tick();
    end

    // ---- both requesters held: 8 display grants then 1 engine grant ----
    dcnt = 0; ecnt = 0; wait_c = 0; max_wait = 0;
    for (int k = 0; k < 30; k++) begin
      bus.disp_req  = (k < 27);
      bus.eng_req   = (k < 27);
      bus.eng_we    = 1'b0;
      bus.disp_addr = 17'h00100 + 17'(dcnt);
      bus.eng_addr  = 17'h00200 + 17'(ecnt);
      @(negedge clk);
      if (bus.disp_rvalid) begin
        if (disp_exp_q.size() == 0) chk("burst_disp_unexpected_rvalid", 1, 0);
        else chk("burst_disp_rdata", 32'(bus.disp_rdata), 32'(disp_exp_q.pop_front()));
      end
      if (bus.eng_rvalid) begin
        if (eng_exp_q.size() == 0) chk("burst_eng_unexpected_rvalid", 1, 0);
        else chk("burst_eng_rdata", 32'(bus.eng_rdata), 32'(eng_exp_q.pop_front()));
      end
      if (k < 27) begin
        chk($sformatf("burst_gnt_k%0d", k), 32'({bus.disp_gnt, bus.eng_gnt}),
            ((k % 9) < 8) ? 32'h2 : 32'h1);
        if (k == 9) chk("burst_last_eng", 32'(last_dbg), 2);
        if (bus.disp_gnt) begin
          disp_exp_q.push_back(init_val({1'b0, bus.disp_addr}));
          dcnt++;
        end
        if (bus.eng_gnt) begin
          eng_exp_q.push_back(init_val({EB, bus.eng_addr}));
          ecnt++;
          if (wait_c > max_wait) max_wait = wait_c;
          wait_c = 0;
        end else begin
          wait_c++;
        end
      end
      tick();
    end
    chk("burst_max_eng_wait", 32'(max_wait), 8);
    chk("burst_disp_q_drained", 32'(disp_exp_q.size()), 0);
    chk("burst_eng_q_drained", 32'(eng_exp_q.size()), 0);

    // ---- reset in the cycle after a display read is accepted ----
    bus.disp_req  = 1'b1;
    bus.disp_addr = 17'h00055;
    @(negedge clk);
    chk("rstflight_accept", 32'(bus.disp_gnt), 1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rstflight_gnt_blocked", 32'({bus.disp_gnt, bus.eng_gnt}), 0);
    tick();
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    check_all_zero("post_rst");
    chk("post_rst_last_idle", 32'(last_dbg), 0);
    rv_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      if (bus.disp_rvalid) rv_cnt++;
    end
    chk("rstflight_no_rvalid", 32'(rv_cnt), 0);
    tick();

`ifdef FB_DOUBLE_BUFFER_EN
    // ---- double buffer: swap mid-frame, applied at end_frame edge ----
    bus.eng_swap = 1'b1;
    tick();
    bus.eng_swap = 1'b0;
    @(negedge clk);
    chk("swap_pending_set", 32'(bus.swap_pending), 1);
    chk("swap_done_idle", 32'(bus.swap_done), 0);
    tick();
    bus.eng_swap = 1'b1;
    tick();
    bus.eng_swap = 1'b0;
    end_frame = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      if (bus.swap_done) done_cnt++;
      if (k == 0) chk("swap_wait_edge", 32'(bus.swap_done), 0);
      if (k == 1) chk("swap_done_at_edge", 32'(bus.swap_done), 1);
      tick();
    end
    chk("swap_once_per_level", 32'(done_cnt), 1);
    chk("swap_pending_cleared", 32'(bus.swap_pending), 0);
    issue_rd(1'b0, 17'h00010, 1'b1, "front1_disp");
    issue_rd(1'b1, 17'h00010, 1'b0, "front1_eng");
    // swap request in the same cycle as the edge
    end_frame = 1'b0;
    tick();
    tick();
    end_frame = 1'b1;
    bus.eng_swap = 1'b1;
    tick();
    bus.eng_swap = 1'b0;
    @(negedge clk);
    chk("swap_same_cycle_done", 32'(bus.swap_done), 1);
    chk("swap_same_cycle_pending", 32'(bus.swap_pending), 0);
    tick();
    issue_rd(1'b0, 17'h00010, 1'b0, "front0_disp");
    issue_rd(1'b1, 17'h00010, 1'b1, "front0_eng");
`else
    // ---- single buffer: swap ignored, buffer bit always 0 ----
    bus.eng_swap = 1'b1;
    tick();
    bus.eng_swap = 1'b0;
    @(negedge clk);
    chk("swap_pending_tied", 32'(bus.swap_pending), 0);
    tick();
    end_frame = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.swap_done) done_cnt++;
      tick();
    end
    chk("swap_done_tied", 32'(done_cnt), 0);
    issue_rd(1'b0, 17'h00010, 1'b0, "single_disp");
    issue_rd(1'b1, 17'h00010, 1'b0, "single_eng");
`endif
    end_frame = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
